twiddle_seq: RTL and testbench
==============================

# twiddle_seq

Parametrised twiddle-factor sequencer for the radix-2 DIT FFT cores in the audio-processing path. On a start request for a given FFT stage, it streams one complex twiddle factor per butterfly, in butterfly order, over a valid/ready interface. Factors come from an elaboration-time quarter-wave cosine table with quadrant folding, so any power-of-two FFT size is supported. It replaces fixed per-size spin tables and adds stage sequencing and backpressure.

## Interface
- LOG2N, 3: FFT size N = 2^LOG2N; legal range 3..10.
- W, 12: signed two's-complement coefficient width.
- AMP, 127: unit-magnitude scale; must satisfy AMP <= 2^(W-1)-1.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous and active-high.
- start  in  1  one-cycle stage request; ignored while busy = 1.
- stage  in  $clog2(LOG2N)  stage index s, 0..LOG2N-1; sampled with start.
- inverse  in  1  conjugate request, sampled with start; present only with TWIDDLE_INVERSE_EN.
- busy  out  1  high from the start-accept edge until the last factor is accepted.
- out_valid  out  1  rea/img hold a valid factor.
- out_ready  in  1  consumer accepts the factor when out_valid & out_ready.
- rea  out  W  twiddle real part.
- img  out  W  twiddle imaginary part.
- out_last  out  1  high with the final factor of the stage.

## Operation
- Table: C[m] = round(AMP*cos(2*pi*m/N)) for m = 0..N/4. It is computed by a constant function at elaboration and stored in N/4+1 entries.
- Stage walk: for butterfly b = 0..N/2-1, j = b mod 2^s and k = j << (LOG2N-1-s). k is always in 0..N/2-1.
- Fold, k < N/4: rea = C[k], img = -C[N/4-k].
- Fold, N/4 <= k < N/2, with m = k-N/4: rea = -C[N/4-m], img = -C[m].
- Negation is W-bit two's complement. With AMP <= 2^(W-1)-1, no overflow or saturation occurs.
- FSM states:
  - IDLE: start=1 moves to RUN, loads s, clears b.
  - RUN: b increments on each pipeline advance; when b = N/2-1 enters its pipeline, moves to DRAIN.
  - DRAIN: waits for the final handshake, then returns to IDLE.
- Pipeline has three stages: P0 index counter, P1 quadrant decode plus table address, P2 table read, sign fold and output register.
- Advance enable: en = ~out_valid | out_ready. All three stages stall together when en = 0.
- Stall rule: rea, img and out_last hold stable while out_valid = 1 and out_ready = 0.
- Start during RUN or DRAIN is dropped, with no effect on the stream or stage.
- A stage value >= LOG2N is clamped to LOG2N-1.

## Timing
- Reset values: busy=0, out_valid=0, out_last=0, rea=0, img=0, FSM=IDLE, b=0.
- Reset mid-stream aborts immediately, and nothing resumes.
- Latency: start is sampled at edge E0; the first out_valid appears after edge E2, with busy=1 after E0.
- Throughput: one factor per cycle while out_ready=1. A stage completes in N/2 + 2 cycles after E0.
- busy falls on the edge that accepts the out_last factor.
- out_valid falls on that same edge unless a new start was sampled in IDLE earlier. A new start is only accepted once busy=0, so streams never overlap.
- out_ready may toggle freely; no factor is dropped or duplicated.

## Configuration
- TWIDDLE_INVERSE_EN defined: the inverse port exists and is latched at start. When latched 1, img is negated after folding (complex conjugate, for IFFT); rea is unchanged.
- TWIDDLE_INVERSE_EN undefined: no inverse port; forward factors only.

## Test plan
- Stage 2, full walk (LOG2N=3, AMP=127, out_ready=1): factors are (127,0), (90,-90), (0,-127), (-90,-90); out_last on the 4th; busy low after it.
- Stage 1 -> (127,0), (0,-127), (127,0), (0,-127). Stage 0 -> four copies of (127,0).
- Backpressure: out_ready low for 3 cycles while holding factor 1 of stage 2. Required: (90,-90) held stable, then exactly 4 accepted factors, in order.
- Start is pulsed during RUN with a different stage. Required: ignored; the stream and out_last count are unchanged.
- rst asserted asynchronously mid-stage. Required: outputs go to 0 before the next edge; a following start for stage 2 restarts from (127,0).
- TWIDDLE_INVERSE_EN defined, inverse=1, stage 2. Required: (127,0), (90,90), (0,127), (-90,90).
- LOG2N=4 stage 3. Required: k=1 gives (117,-49), and k=6 gives (-90,-90).

Source files
------------

// File: rtl/twiddle_seq.sv
// rtl/twiddle_seq.sv - radix-2 DIT FFT twiddle-factor sequencer; optional conjugate output via TWIDDLE_INVERSE_EN
module twiddle_seq #(
    parameter int LOG2N = 3,
    parameter int W     = 12,
    parameter int AMP   = 127
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [$clog2(LOG2N)-1:0] stage,
`ifdef TWIDDLE_INVERSE_EN
    input  logic                     inverse,
`endif
    output logic                     busy,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [W-1:0]      rea,
    output logic signed [W-1:0]      img,
    output logic                     out_last
);

    localparam int SW = $clog2(LOG2N);
    // Butterfly index, twiddle exponent k and table address all share this width.
    localparam int BW = LOG2N - 1;
    localparam int Q  = 1 << (LOG2N - 2);
    localparam logic [BW-1:0] B_LAST = {BW{1'b1}};
    localparam logic [BW-1:0] Q_ADDR = BW'(Q);
    localparam logic [SW-1:0] S_MAX  = SW'(LOG2N - 1);

    // round(AMP*cos(2*pi*m/N)) for the first quadrant, via a Taylor series so no math library is needed.
    function automatic logic signed [W-1:0] cos_entry(input int m);
        real x;
        real term;
        real sum;
        x    = 2.0 * 3.14159265358979323846 * real'(m) / real'(1 << LOG2N);
        term = 1.0;
        sum  = 1.0;
        for (int i = 1; i < 16; i++) begin
            term = -term * x * x / real'((2 * i - 1) * (2 * i));
            sum  = sum + term;
        end
        return W'($rtoi(real'(AMP) * sum + 0.5));
    endfunction

    logic signed [W-1:0] c_tab [0:Q];
    for (genvar g = 0; g <= Q; g++) begin : g_tab
        localparam logic signed [W-1:0] CV = cos_entry(g);
        assign c_tab[g] = CV;
    end

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t state, state_nxt;

    logic [SW-1:0] s_q;
    logic [BW-1:0] b_q;
    logic          inv_q;
    logic          inv_req;
    logic [SW-1:0] stage_clamped;
    logic          en;
    logic          accept_last;

`ifdef TWIDDLE_INVERSE_EN
    assign inv_req = inverse;
`else
    assign inv_req = 1'b0;
`endif

    assign en            = ~out_valid | out_ready;
    assign accept_last   = out_valid & out_ready & out_last;
    assign stage_clamped = (stage > S_MAX) ? S_MAX : stage;
    assign busy          = (state != IDLE);

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state: RUN feeds butterflies into the pipe, DRAIN waits for the last one to be taken.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (en && b_q == B_LAST) state_nxt = DRAIN;
            DRAIN:   if (accept_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // P0: stage/conjugate capture and butterfly counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q   <= '0;
            b_q   <= '0;
            inv_q <= 1'b0;
        end else if (state == IDLE && start) begin
            s_q   <= stage_clamped;
            b_q   <= '0;
            inv_q <= inv_req;
        end else if (state == RUN && en) begin
            b_q <= b_q + 1'b1;
        end
    end

    logic [BW-1:0] j_mask, k_val, m_val, addr_re, addr_im;
    logic          neg_re;

    // Exponent k = (b mod 2^s) << (LOG2N-1-s), folded onto the quarter-wave table.
    always_comb begin
        j_mask  = BW'((32'd1 << s_q) - 32'd1);
        k_val   = (b_q & j_mask) << (BW - int'(s_q));
        m_val   = {1'b0, k_val[BW-2:0]};
        addr_re = k_val;
        addr_im = Q_ADDR - k_val;
        neg_re  = 1'b0;
        if (k_val[BW-1]) begin
            addr_re = Q_ADDR - m_val;
            addr_im = m_val;
            neg_re  = 1'b1;
        end
    end

    logic          p1_valid, p1_last, p1_neg_re;
    logic [BW-1:0] p1_addr_re, p1_addr_im;

    // P1: quadrant decode result and table addresses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p1_valid   <= 1'b0;
            p1_last    <= 1'b0;
            p1_neg_re  <= 1'b0;
            p1_addr_re <= '0;
            p1_addr_im <= '0;
        end else if (en) begin
            p1_valid   <= (state == RUN);
            p1_last    <= (state == RUN) && (b_q == B_LAST);
            p1_neg_re  <= neg_re;
            p1_addr_re <= addr_re;
            p1_addr_im <= addr_im;
        end
    end

    // P2: table read and sign fold; img is always negated in the forward direction, conjugate undoes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            rea       <= '0;
            img       <= '0;
        end else if (en) begin
            out_valid <= p1_valid;
            out_last  <= p1_valid & p1_last;
            if (p1_valid) begin
                rea <= p1_neg_re ? -c_tab[p1_addr_re] : c_tab[p1_addr_re];
                img <= inv_q ? c_tab[p1_addr_im] : -c_tab[p1_addr_im];
            end
        end
    end

endmodule

// File: tb/tb_twiddle_seq.sv
// tb/tb_twiddle_seq.sv - scoreboard bench for twiddle_seq (LOG2N=3 and LOG2N=4 instances)
module tb_twiddle_seq;

    localparam int  W   = 12;
    localparam int  AMP = 127;
    localparam int  L3  = 3;
    localparam int  L4  = 4;
    localparam real PI  = 3.14159265358979323846;
`ifdef TWIDDLE_INVERSE_EN
    localparam bit  INV_EN = 1'b1;
`else
    localparam bit  INV_EN = 1'b0;
`endif

    typedef struct {
        int re;
        int im;
        bit last;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic start, inverse, out_ready;
    logic [1:0] stage;
    logic busy, out_valid, out_last;
    logic signed [W-1:0] rea, img;

    logic start16, inverse16, ready16;
    logic [1:0] stage16;
    logic busy16, out_valid16, out_last16;
    logic signed [W-1:0] rea16, img16;

    int n_tests = 0;
    int n_fail  = 0;
    int acc_cnt = 0;
    int last_cnt = 0;
    bit rnd_ready = 1'b0;

    exp_t sbq[$];
    exp_t sbq16[$];

    initial forever #5 clk = ~clk;

    twiddle_seq #(.LOG2N(L3), .W(W), .AMP(AMP)) u_dut (
        .clk(clk), .rst(rst), .start(start), .stage(stage),
`ifdef TWIDDLE_INVERSE_EN
        .inverse(inverse),
`endif
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .rea(rea), .img(img), .out_last(out_last)
    );

    twiddle_seq #(.LOG2N(L4), .W(W), .AMP(AMP)) u_dut16 (
        .clk(clk), .rst(rst), .start(start16), .stage(stage16),
`ifdef TWIDDLE_INVERSE_EN
        .inverse(inverse16),
`endif
        .busy(busy16), .out_valid(out_valid16), .out_ready(ready16),
        .rea(rea16), .img(img16), .out_last(out_last16)
    );

    function automatic void check(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    function automatic int rnd(real x);
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
    endfunction

    // Reference: twiddle W_N^k = exp(-2*pi*i*k/N), scaled by AMP and rounded.
    function automatic exp_t model(int log2n, int s_raw, int b, bit inv);
        exp_t e;
        int   n, s, k;
        real  th;
        n    = 1 << log2n;
        s    = (s_raw >= log2n) ? log2n - 1 : s_raw;
        k    = (b % (1 << s)) * (n >> (s + 1));
        th   = 2.0 * PI * real'(k) / real'(n);
        e.re = rnd(real'(AMP) * $cos(th));
        e.im = -rnd(real'(AMP) * $sin(th));
        if (inv && INV_EN) e.im = -e.im;
        e.last = (b == n / 2 - 1);
        return e;
    endfunction

    task automatic push_one(int re, int im, bit last);
        exp_t e;
        e.re = re; e.im = im; e.last = last;
        sbq.push_back(e);
    endtask

    task automatic push_main(int s, bit inv);
        for (int b = 0; b < (1 << L3) / 2; b++) sbq.push_back(model(L3, s, b, inv));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_free();
        int n = 0;
        while (busy && n < 200) begin tick(); n++; end
        if (busy) check("busy_timeout", int'(busy), 0);
    endtask

    task automatic do_start(int s, bit inv, bit push);
        wait_free();
        start = 1'b1; stage = 2'(s); inverse = inv;
        if (push) push_main(s, inv);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((busy || out_valid || sbq.size() != 0) && n < 400) begin tick(); n++; end
        check("drain_idle", int'(busy || out_valid), 0);
        check("sb_empty", sbq.size(), 0);
    endtask

    // Monitor: pop and compare on every handshake; outputs must hold while stalled.
    bit held = 1'b0;
    int h_re, h_im, h_last;
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst) begin
            held = 1'b0;
        end else begin
            if (held) begin
                check("hold_rea", int'(rea), h_re);
                check("hold_img", int'(img), h_im);
                check("hold_last", int'(out_last), h_last);
            end
            if (out_valid && out_ready) begin
                acc_cnt++;
                if (out_last) last_cnt++;
                check("sb_nonempty", int'(sbq.size() > 0), 1);
                if (sbq.size() > 0) begin
                    e = sbq.pop_front();
                    check("rea", int'(rea), e.re);
                    check("img", int'(img), e.im);
                    check("last", int'(out_last), int'(e.last));
                end
            end
            held   = out_valid && !out_ready;
            h_re   = int'(rea);
            h_im   = int'(img);
            h_last = int'(out_last);
            if (out_valid16 && ready16) begin
                check("sb16_nonempty", int'(sbq16.size() > 0), 1);
                if (sbq16.size() > 0) begin
                    e = sbq16.pop_front();
                    check("rea16", int'(rea16), e.re);
                    check("img16", int'(img16), e.im);
                    check("last16", int'(out_last16), int'(e.last));
                end
            end
        end
    end

    initial begin
        int   cyc, base, lbase, n, s;
        bit   inv;
        exp_t e;
        rst = 1'b1; start = 1'b0; stage = '0; inverse = 1'b0; out_ready = 1'b1;
        start16 = 1'b0; stage16 = '0; inverse16 = 1'b0; ready16 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_valid", int'(out_valid), 0);
        check("rst_last", int'(out_last), 0);
        check("rst_rea", int'(rea), 0);
        check("rst_img", int'(img), 0);
        rst = 1'b0;
        tick();

        // Stage 2 full walk with latency and completion time.
        push_one(127, 0, 0); push_one(90, -90, 0); push_one(0, -127, 0); push_one(-90, -90, 1);
        start = 1'b1; stage = 2'd2;
        tick();
        start = 1'b0;
        check("e0_busy", int'(busy), 1);
        check("e0_valid", int'(out_valid), 0);
        tick();
        check("e1_valid", int'(out_valid), 0);
        tick();
        check("e2_valid", int'(out_valid), 1);
        cyc = 2;
        while (busy && cyc < 50) begin tick(); cyc++; end
        check("stage_cycles", cyc, 6);
        check("valid_after_last", int'(out_valid), 0);
        check("sb_empty_t1", sbq.size(), 0);

        // Stage 1 and stage 0.
        push_one(127, 0, 0); push_one(0, -127, 0); push_one(127, 0, 0); push_one(0, -127, 1);
        do_start(1, 1'b0, 1'b0);
        wait_done();
        push_one(127, 0, 0); push_one(127, 0, 0); push_one(127, 0, 0); push_one(127, 0, 1);
        do_start(0, 1'b0, 1'b0);
        wait_done();

        // Backpressure on factor 1 of stage 2.
        base = acc_cnt;
        do_start(2, 1'b0, 1'b1);
        n = 0;
        while (acc_cnt < base + 1 && n < 50) begin tick(); n++; end
        out_ready = 1'b0;
        check("bp_rea", int'(rea), 90);
        check("bp_img", int'(img), -90);
        repeat (3) tick();
        check("bp_rea_held", int'(rea), 90);
        check("bp_valid_held", int'(out_valid), 1);
        out_ready = 1'b1;
        wait_done();
        check("bp_count", acc_cnt - base, 4);

        // Start pulses during RUN and DRAIN are dropped.
        base = acc_cnt; lbase = last_cnt;
        do_start(2, 1'b0, 1'b1);
        start = 1'b1; stage = 2'd0;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1; stage = 2'd1;
        tick();
        start = 1'b0;
        wait_done();
        check("ign_count", acc_cnt - base, 4);
        check("ign_last", last_cnt - lbase, 1);

        // Asynchronous reset mid-stage, then a clean restart.
        base = acc_cnt;
        do_start(1, 1'b0, 1'b1);
        n = 0;
        while (acc_cnt < base + 2 && n < 50) begin tick(); n++; end
        #2 rst = 1'b1;
        #1;
        check("arst_busy", int'(busy), 0);
        check("arst_valid", int'(out_valid), 0);
        check("arst_last", int'(out_last), 0);
        check("arst_rea", int'(rea), 0);
        check("arst_img", int'(img), 0);
        sbq.delete();
        @(negedge clk) rst = 1'b0;
        repeat (3) tick();
        check("no_resume_valid", int'(out_valid), 0);
        check("no_resume_busy", int'(busy), 0);
        push_one(127, 0, 0); push_one(90, -90, 0); push_one(0, -127, 0); push_one(-90, -90, 1);
        do_start(2, 1'b0, 1'b0);
        wait_done();

`ifdef TWIDDLE_INVERSE_EN
        push_one(127, 0, 0); push_one(90, 90, 0); push_one(0, 127, 0); push_one(-90, 90, 1);
        do_start(2, 1'b1, 1'b0);
        wait_done();
`endif

        // Randomized stages (3 exercises the clamp) with random backpressure.
        rnd_ready = 1'b1;
        for (int t = 0; t < 30; t++) begin
            s   = int'($urandom_range(0, 3));
            inv = 1'($urandom_range(0, 1));
            do_start(s, inv, 1'b1);
        end
        wait_done();
        rnd_ready = 1'b0;
        out_ready = 1'b1;

        // LOG2N=4: stage 3 with the two spot values, then a few random stages.
        for (int b = 0; b < 8; b++) begin
            e = model(L4, 3, b, 1'b0);
            if (b == 1) begin e.re = 117; e.im = -49; end
            if (b == 6) begin e.re = -90; e.im = -90; end
            sbq16.push_back(e);
        end
        start16 = 1'b1; stage16 = 2'd3;
        tick();
        start16 = 1'b0;
        for (int t = 0; t < 4; t++) begin
            n = 0;
            while (busy16 && n < 100) begin tick(); n++; end
            check("busy16_free", int'(busy16), 0);
            s = int'($urandom_range(0, 3));
            for (int b = 0; b < 8; b++) sbq16.push_back(model(L4, s, b, 1'b0));
            start16 = 1'b1; stage16 = 2'(s);
            tick();
            start16 = 1'b0;
        end
        n = 0;
        while ((busy16 || sbq16.size() != 0) && n < 200) begin tick(); n++; end
        check("sb16_empty", sbq16.size(), 0);
        check("busy16_idle", int'(busy16), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
